ps2_command_tx: RTL and testbench
=================================

Name: ps2_command_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable), using the standard inhibit / request-to-send / device-clocked sequence. It sits beside PS2_Controller in tetris and shares the same PS2_CLK/PS2_DAT pins through open-drain enables. It also raises busy so the top level can gate ps2_key_pressed during a transmission.

Parameters:
INHIBIT_CYCLES, 5000, clock-low hold before request-to-send (100 us at 50 MHz).
START_TIMEOUT_CYCLES, 750000, maximum wait from clock release to the first device falling edge (15 ms).
XFER_TIMEOUT_CYCLES, 100000, maximum time from the first falling edge to the ACK edge (2 ms).
TIMER_W, 20, timer width; must hold the largest of the three cycle counts above.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
Resetn  in  1  asynchronous active-low reset.
command  in  8  byte to send; sampled on acceptance.
send_command  in  1  one-cycle request strobe.
ps2_clk_in  in  1  raw PS2_CLK pin value (asynchronous).
ps2_dat_in  in  1  raw PS2_DAT pin value (asynchronous).
ps2_clk_drive_low  out  1  1 = pull PS2_CLK low; 0 = release (high-Z).
ps2_dat_drive_low  out  1  1 = pull PS2_DAT low; 0 = release.
busy  out  1  high in every state except IDLE.
command_was_sent  out  1  one-cycle pulse: device ACKed.
error_timeout  out  1  one-cycle pulse: a timeout expired.
error_nack  out  1  one-cycle pulse: ACK bit sampled high.

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, both lines released; takes effect immediately, including mid-transfer.
- Input sync: ps2_clk_in and ps2_dat_in each pass through 2 flops. A falling edge is detected as prev=1, cur=0 on the synchronized clock (3-cycle latency from the pin).
- Odd parity: parity bit = ~^command_latched.
- IDLE:
  - send_command=1 latches command, clears the timer, goes to INHIBIT.
  - send_command is ignored in every other state; no queueing.
- INHIBIT:
  - clk_drive_low=1, dat_drive_low=0.
  - When the timer reaches INHIBIT_CYCLES-1: set dat_drive_low=1 (start bit), set clk_drive_low=0, clear the timer, go to RTS.
- RTS:
  - Wait for the first falling edge; the timer runs.
  - Timer reaching START_TIMEOUT_CYCLES-1: release both lines, pulse error_timeout, go to IDLE.
  - On the edge: drive data bit0 (dat_drive_low = ~bit), set bit_cnt=1, clear the timer, go to SEND.
- SEND, on each falling edge:
  - bit_cnt 1..7: drive data bit[bit_cnt].
  - bit_cnt 8: drive the parity bit.
  - bit_cnt 9: release data (stop bit), go to ACK.
  - bit_cnt increments on each edge; 4-bit counter.
- ACK: on the next falling edge, sample synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: release lines, pulse error_nack, go to IDLE.
- WAIT_IDLE: wait until synchronized clk=1 and dat=1 for the same cycle, then pulse command_was_sent and go to IDLE.
- The XFER timer runs continuously through SEND, ACK and WAIT_IDLE and is not reset per bit. Timer reaching XFER_TIMEOUT_CYCLES-1: release lines, pulse error_timeout, go to IDLE.
- Line update timing: the drive outputs change on the cycle after edge detection, well inside the device's clock-low phase.
- Pulse exclusivity: at most one of command_was_sent, error_timeout, error_nack fires per command. busy falls in the same cycle the pulse is asserted.
- The block never drives a line high; the top level maps drive_low=1 to pin 0 and drive_low=0 to 'z'.

Decomposition:
- Shared package ps2_pkg:
  - State enum {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE}.
  - Command constants: PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_TYPEMATIC=8'hF3, PS2_ACK_BYTE=8'hFA.
  - Default timing constants.
- Sub-module ps2_line_sync: 2-flop synchronizers for both lines plus clock falling-edge detect. PS2_Controller can reuse it later.

Test Plan:
1. Send 0xED with a bench device model (40 us clock half-period, ACK low):
   - Clock held low 5000 cycles, then data low and clock released.
   - Bits sampled on rising edges: 1,0,1,1,0,1,1,1; parity 1; stop 1.
   - command_was_sent pulses once and busy returns to 0.
2. Parity check: 0xFF gives parity 1; 0x01 gives parity 0; 0x00 gives parity 1. Each is checked bit-exact on the line.
3. No device clock after release: error_timeout pulses exactly 5000+750000 cycles (±sync latency) after acceptance. Both lines are released and busy=0.
4. Device leaves data high in the ACK slot: error_nack pulses; command_was_sent stays 0.
5. Second send_command=1 (0xF4) issued during SEND of 0xED: ignored. Only 0xED appears on the line and exactly one completion pulse occurs.
6. Resetn low during SEND bit 4: drive outputs go to 0 asynchronously with no clock edge needed. After release, a fresh 0xFF send completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes and default timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE    = 8'hF4;
    localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] PS2_ACK_BYTE      = 8'hFA;

    // Defaults assume a 50 MHz system clock.
    localparam int PS2_INHIBIT_CYCLES       = 5000;
    localparam int PS2_START_TIMEOUT_CYCLES = 750000;
    localparam int PS2_XFER_TIMEOUT_CYCLES  = 100000;
    localparam int PS2_TIMER_W              = 20;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for PS2_CLK / PS2_DAT plus a falling-edge strobe on the clock line.
module ps2_line_sync (
    input  logic CLOCK_50,
    input  logic Resetn,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic clk_meta;
    logic dat_meta;
    logic clk_prev;

    // Flops reset to the idle-high bus level so leaving reset cannot fake an edge.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, then shifts one byte
// out on device-generated clock edges and checks the device ACK.
module ps2_command_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = PS2_INHIBIT_CYCLES,
    parameter int START_TIMEOUT_CYCLES = PS2_START_TIMEOUT_CYCLES,
    parameter int XFER_TIMEOUT_CYCLES  = PS2_XFER_TIMEOUT_CYCLES,
    parameter int TIMER_W              = PS2_TIMER_W
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timeout,
    output logic       error_nack
);

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_TIMEOUT_CYCLES - 1);

    ps2_tx_state_t      state;
    logic [7:0]         cmd_latched;
    logic [3:0]         bit_cnt;
    logic [TIMER_W-1:0] timer;

    logic clk_sync;
    logic dat_sync;
    logic clk_fall;
    logic parity_bit;
    logic xfer_expired;

    ps2_line_sync u_line_sync (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_sync   (clk_sync),
        .dat_sync   (dat_sync),
        .clk_fall   (clk_fall)
    );

    assign parity_bit   = odd_parity(cmd_latched);
    assign xfer_expired = (timer == XFER_LAST);

    // The transfer timer is never cleared per bit, so it bounds the whole byte plus ACK.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state             <= IDLE;
            cmd_latched       <= '0;
            bit_cnt           <= '0;
            timer             <= '0;
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            busy              <= 1'b0;
            command_was_sent  <= 1'b0;
            error_timeout     <= 1'b0;
            error_nack        <= 1'b0;
        end else begin
            command_was_sent <= 1'b0;
            error_timeout    <= 1'b0;
            error_nack       <= 1'b0;

            case (state)
                IDLE: begin
                    if (send_command) begin
                        cmd_latched       <= command;
                        timer             <= '0;
                        ps2_clk_drive_low <= 1'b1;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b1;
                        state             <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b1;
                        timer             <= '0;
                        state             <= RTS;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                RTS: begin
                    if (clk_fall) begin
                        ps2_dat_drive_low <= ~cmd_latched[0];
                        bit_cnt           <= 4'd1;
                        timer             <= '0;
                        state             <= SEND;
                    end else if (timer == START_LAST) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timeout     <= 1'b1;
                        state             <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                SEND: begin
                    timer <= timer + 1'b1;
                    if (xfer_expired) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timeout     <= 1'b1;
                        state             <= IDLE;
                    end else if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            ps2_dat_drive_low <= 1'b0;
                            state             <= ACK;
                        end else if (bit_cnt == 4'd8) begin
                            ps2_dat_drive_low <= ~parity_bit;
                        end else begin
                            ps2_dat_drive_low <= ~cmd_latched[bit_cnt[2:0]];
                        end
                    end
                end

                ACK: begin
                    timer <= timer + 1'b1;
                    if (xfer_expired) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timeout     <= 1'b1;
                        state             <= IDLE;
                    end else if (clk_fall) begin
                        if (!dat_sync) begin
                            state <= WAIT_IDLE;
                        end else begin
                            ps2_clk_drive_low <= 1'b0;
                            ps2_dat_drive_low <= 1'b0;
                            busy              <= 1'b0;
                            error_nack        <= 1'b1;
                            state             <= IDLE;
                        end
                    end
                end

                WAIT_IDLE: begin
                    timer <= timer + 1'b1;
                    if (xfer_expired) begin
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        error_timeout     <= 1'b1;
                        state             <= IDLE;
                    end else if (clk_sync && dat_sync) begin
                        busy             <= 1'b0;
                        command_was_sent <= 1'b1;
                        state            <= IDLE;
                    end
                end

                default: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx with a simple keyboard model on the shared open-drain lines.
module tb_ps2_command_tx;
    import ps2_pkg::*;

    localparam int INHIBIT  = 50;
    localparam int START_TO = 400;
    localparam int XFER_TO  = 2000;
    localparam int TW       = 12;
    localparam int HP       = 20;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b1;
    logic [7:0] command = 8'h00;
    logic       send_command = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       busy;
    logic       command_was_sent;
    logic       error_timeout;
    logic       error_nack;

    int n_checks = 0;
    int n_fail = 0;
    int sent_cnt = 0;
    int timeout_cnt = 0;
    int nack_cnt = 0;
    int busy_at_pulse = 0;

    // Wired-AND of host and device pull-downs.
    assign ps2_clk_in = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_drive_low | dev_dat_low);

    ps2_command_tx #(
        .INHIBIT_CYCLES       (INHIBIT),
        .START_TIMEOUT_CYCLES (START_TO),
        .XFER_TIMEOUT_CYCLES  (XFER_TO),
        .TIMER_W              (TW)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .Resetn            (Resetn),
        .command           (command),
        .send_command      (send_command),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_dat_in        (ps2_dat_in),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_dat_drive_low (ps2_dat_drive_low),
        .busy              (busy),
        .command_was_sent  (command_was_sent),
        .error_timeout     (error_timeout),
        .error_nack        (error_nack)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (command_was_sent) sent_cnt++;
        if (error_timeout) timeout_cnt++;
        if (error_nack) nack_cnt++;
        if ((command_was_sent || error_timeout || error_nack) && busy) busy_at_pulse++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] cmd);
        @(negedge CLOCK_50);
        command      = cmd;
        send_command = 1'b1;
        @(negedge CLOCK_50);
        send_command = 1'b0;
    endtask

    task automatic waitRts(output int inhibit_len);
        inhibit_len = 0;
        while (ps2_clk_drive_low && inhibit_len < 1000) begin
            @(negedge CLOCK_50);
            inhibit_len++;
        end
    endtask

    // Device clocks 10 bits (data, parity, stop) sampling on rising edges, then the ACK slot.
    task automatic deviceClock(input logic ack_low, output logic [9:0] frame);
        frame = '0;
        repeat (HP) @(negedge CLOCK_50);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            frame[i] = ps2_dat_in;
            repeat (HP) @(negedge CLOCK_50);
        end
        if (ack_low) dev_dat_low = 1'b1;
        repeat (HP / 2) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;
        repeat (HP) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (HP / 2) @(negedge CLOCK_50);
        dev_dat_low = 1'b0;
        repeat (HP) @(negedge CLOCK_50);
    endtask

    task automatic runCommand(input logic [7:0] cmd, input logic ack_low, input string tag,
                              input logic [9:0] exp_frame, input int exp_sent, input int exp_nack);
        int base_sent;
        int base_nack;
        int base_to;
        int inh;
        logic [9:0] fr;
        base_sent = sent_cnt;
        base_nack = nack_cnt;
        base_to   = timeout_cnt;
        applyStimulus(cmd);
        waitRts(inh);
        checkOutput({tag, "_inhibit_len"}, 32'(inh), INHIBIT);
        checkOutput({tag, "_start_bit"}, 32'(ps2_dat_drive_low), 32'd1);
        deviceClock(ack_low, fr);
        repeat (10) @(negedge CLOCK_50);
        checkOutput({tag, "_frame"}, 32'(fr), 32'(exp_frame));
        checkOutput({tag, "_sent"}, 32'(sent_cnt - base_sent), 32'(exp_sent));
        checkOutput({tag, "_nack"}, 32'(nack_cnt - base_nack), 32'(exp_nack));
        checkOutput({tag, "_timeout"}, 32'(timeout_cnt - base_to), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        int inh;
        int base_sent;
        int base_to;
        logic [9:0] fr;

        #5 Resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("reset_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
        checkOutput("reset_dat_drive", 32'(ps2_dat_drive_low), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pulses", 32'({command_was_sent, error_timeout, error_nack}), 32'd0);
        Resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Frames are {stop, parity, data[7:0]} as sampled, with odd parity worked by hand.
        runCommand(PS2_CMD_SET_LEDS, 1'b1, "set_leds", 10'h3ED, 1, 0);
        runCommand(PS2_CMD_RESET, 1'b1, "cmd_ff", 10'h3FF, 1, 0);
        runCommand(8'h01, 1'b1, "cmd_01", 10'h201, 1, 0);
        runCommand(8'h00, 1'b1, "cmd_00", 10'h300, 1, 0);

        base_to = timeout_cnt;
        applyStimulus(PS2_CMD_ENABLE);
        cnt = 0;
        while (!error_timeout && cnt < 2000) begin
            @(negedge CLOCK_50);
            cnt++;
        end
        checkOutput("start_timeout_latency", 32'(cnt), 32'(INHIBIT + START_TO));
        checkOutput("start_timeout_lines", 32'({ps2_clk_drive_low, ps2_dat_drive_low}), 32'd0);
        checkOutput("start_timeout_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge CLOCK_50);
        checkOutput("start_timeout_count", 32'(timeout_cnt - base_to), 32'd1);

        runCommand(PS2_CMD_ENABLE, 1'b0, "nack", 10'h2F4, 0, 1);

        base_sent = sent_cnt;
        applyStimulus(PS2_CMD_SET_LEDS);
        waitRts(inh);
        fork
            deviceClock(1'b1, fr);
            begin
                repeat (HP * 8) @(negedge CLOCK_50);
                command      = PS2_CMD_ENABLE;
                send_command = 1'b1;
                @(negedge CLOCK_50);
                send_command = 1'b0;
            end
        join
        repeat (10) @(negedge CLOCK_50);
        checkOutput("ignored_send_frame", 32'(fr), 32'h3ED);
        checkOutput("ignored_send_sent", 32'(sent_cnt - base_sent), 32'd1);
        repeat (200) @(negedge CLOCK_50);
        checkOutput("ignored_send_no_queue", 32'({busy, ps2_clk_drive_low}), 32'd0);
        checkOutput("ignored_send_sent_later", 32'(sent_cnt - base_sent), 32'd1);

        // Stop the device with clock low just after the host puts bit4 (0 for 0xED) on the line.
        base_sent = sent_cnt;
        applyStimulus(PS2_CMD_SET_LEDS);
        waitRts(inh);
        repeat (HP) @(negedge CLOCK_50);
        for (int i = 0; i < 5; i++) begin
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge CLOCK_50);
            if (i < 4) begin
                dev_clk_low = 1'b0;
                repeat (HP) @(negedge CLOCK_50);
            end
        end
        checkOutput("mid_send_bit4_drive", 32'(ps2_dat_drive_low), 32'd1);
        checkOutput("mid_send_busy", 32'(busy), 32'd1);
        #3 Resetn = 1'b0;
        #1;
        checkOutput("async_reset_lines", 32'({ps2_clk_drive_low, ps2_dat_drive_low}), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        Resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        checkOutput("reset_abort_no_sent", 32'(sent_cnt - base_sent), 32'd0);
        runCommand(PS2_CMD_RESET, 1'b1, "after_reset", 10'h3FF, 1, 0);

        checkOutput("busy_low_at_pulse", 32'(busy_at_pulse), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
